// File: rtl/bp_be_dcache_req_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : bp_be_dcache_req_arbiter                                      |
// | Purpose  : Arbitrates LSU (req0) and page-table walker (req1) dcache     |
// |            requests into a single registered dcache request port, with   |
// |            req0 anti-starvation and fencei completion tracking.          |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+

package bp_be_dcache_req_arbiter_pkg;

  typedef enum logic [0:0] {
    e_bp_default_cfg = 1'b0
  } bp_params_e;

  localparam int dcache_opcode_width_gp = 5;
  localparam int page_offset_width_gp   = 12;
  localparam int dword_width_gp         = 64;

  // Dcache opcodes; only fencei is ever decoded by the arbiter.
  typedef enum logic [dcache_opcode_width_gp-1:0] {
    e_dcache_op_lb     = 5'd0,
    e_dcache_op_lh     = 5'd1,
    e_dcache_op_lw     = 5'd2,
    e_dcache_op_ld     = 5'd3,
    e_dcache_op_lbu    = 5'd4,
    e_dcache_op_lhu    = 5'd5,
    e_dcache_op_lwu    = 5'd6,
    e_dcache_op_sb     = 5'd8,
    e_dcache_op_sh     = 5'd9,
    e_dcache_op_sw     = 5'd10,
    e_dcache_op_sd     = 5'd11,
    e_dcache_op_fencei = 5'd20
  } bp_be_dcache_opcode_e;

  // Packet layout (MSB first): {opcode, page_offset, data}.
  function automatic int dcache_pkt_width(bp_params_e cfg);
    case (cfg)
      e_bp_default_cfg: return dcache_opcode_width_gp + page_offset_width_gp + dword_width_gp;
      default:          return dcache_opcode_width_gp + page_offset_width_gp + dword_width_gp;
    endcase
  endfunction

endpackage

module bp_be_dcache_req_arbiter
  import bp_be_dcache_req_arbiter_pkg::*;
  #(parameter bp_params_e bp_params_p = e_bp_default_cfg
   ,parameter int starve_limit_p = 4
   ,localparam int dcache_pkt_width_lp = dcache_pkt_width(bp_params_p)
   )
  (input  logic                           clk_i
  ,input  logic                           reset_n_i

  ,input  logic                           req0_v_i
  ,input  logic [dcache_pkt_width_lp-1:0] req0_pkt_i
  ,output logic                           req0_ready_o

  ,input  logic                           req1_v_i
  ,input  logic [dcache_pkt_width_lp-1:0] req1_pkt_i
  ,output logic                           req1_ready_o

  ,output logic                           dcache_v_o
  ,output logic [dcache_pkt_width_lp-1:0] dcache_pkt_o
  ,input  logic                           dcache_ready_i
  ,output logic                           grant_id_o

  ,input  logic                           fence_done_i
  ,output logic                           busy_o
  );

  typedef enum logic [1:0] {
    e_idle  = 2'd0,
    e_hold  = 2'd1,
    e_fence = 2'd2
  } state_e;

  localparam logic [3:0] starve_limit_lp = 4'(starve_limit_p);

  state_e                         state_q, state_n;
  logic [dcache_pkt_width_lp-1:0] pkt_q;
  logic                           grant_id_q;
  logic [3:0]                     starve_q;

  logic [dcache_opcode_width_gp-1:0] held_opcode;
  logic held_fencei;
  logic accept_window;
  logic starve_below_limit;
  logic win0, win1;
  logic handshake;

  assign held_opcode        = pkt_q[dcache_pkt_width_lp-1 -: dcache_opcode_width_gp];
  assign held_fencei        = (held_opcode == e_dcache_op_fencei);
  assign starve_below_limit = (starve_q < starve_limit_lp);

  // A new packet may be taken when nothing is held, or the held one retires
  // this cycle and is not a fence (a fence must drain before anything else).
  assign accept_window = reset_n_i
                       & ((state_q == e_idle)
                          | ((state_q == e_hold) & dcache_ready_i & ~held_fencei));

  // req1 wins unless req0 has been starved to the limit; req1 also takes the
  // slot if req0 is idle.
  assign win1 = req1_v_i & (starve_below_limit | ~req0_v_i);
  assign win0 = req0_v_i & ~(req1_v_i & starve_below_limit);

  assign req0_ready_o = accept_window & win0;
  assign req1_ready_o = accept_window & win1;
  assign handshake    = req0_ready_o | req1_ready_o;

  assign dcache_v_o   = (state_q == e_hold);
  assign dcache_pkt_o = pkt_q;
  assign grant_id_o   = grant_id_q;
  assign busy_o       = (state_q != e_idle);

  // Next-state selection for the hold / fence sequencing.
  always_comb begin
    state_n = state_q;
    case (state_q)
      e_idle: begin
        if (handshake) state_n = e_hold;
      end
      e_hold: begin
        if (dcache_ready_i) begin
          if (held_fencei)    state_n = e_fence;
          else if (handshake) state_n = e_hold;
          else                state_n = e_idle;
        end
      end
      e_fence: begin
        if (fence_done_i) state_n = e_idle;
      end
      default: state_n = e_idle;
    endcase
  end

  // State register and held packet/ID; a handshake always loads the winner.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q    <= e_idle;
      pkt_q      <= '0;
      grant_id_q <= 1'b0;
    end else begin
      state_q <= state_n;
      if (handshake) begin
        pkt_q      <= req1_ready_o ? req1_pkt_i : req0_pkt_i;
        grant_id_q <= req1_ready_o;
      end
    end
  end

  // Consecutive req0 losses; saturates at the limit, cleared on a req0 grant.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      starve_q <= 4'd0;
    end else if (req1_ready_o & req0_v_i) begin
      if (starve_below_limit) starve_q <= starve_q + 4'd1;
    end else if (req0_ready_o) begin
      starve_q <= 4'd0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bp_be_dcache_req_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_bp_be_dcache_req_arbiter                                   |
// | Purpose  : Self-checking bench for bp_be_dcache_req_arbiter: directed     |
// |            scenarios followed by randomized traffic against a reference   |
// |            model of the arbitration rules.                                |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_bp_be_dcache_req_arbiter;
  import bp_be_dcache_req_arbiter_pkg::*;

  localparam int W     = dcache_pkt_width(e_bp_default_cfg);
  localparam int LIMIT = 4;
  localparam int OPW   = dcache_opcode_width_gp;

  logic         clk = 1'b0;
  logic         reset_n_i;
  logic         req0_v_i, req1_v_i;
  logic [W-1:0] req0_pkt_i, req1_pkt_i;
  logic         req0_ready_o, req1_ready_o;
  logic         dcache_v_o;
  logic [W-1:0] dcache_pkt_o;
  logic         dcache_ready_i;
  logic         grant_id_o;
  logic         fence_done_i;
  logic         busy_o;

  bp_be_dcache_req_arbiter #(.bp_params_p(e_bp_default_cfg), .starve_limit_p(LIMIT)) dut (
    .clk_i(clk), .reset_n_i(reset_n_i),
    .req0_v_i(req0_v_i), .req0_pkt_i(req0_pkt_i), .req0_ready_o(req0_ready_o),
    .req1_v_i(req1_v_i), .req1_pkt_i(req1_pkt_i), .req1_ready_o(req1_ready_o),
    .dcache_v_o(dcache_v_o), .dcache_pkt_o(dcache_pkt_o), .dcache_ready_i(dcache_ready_i),
    .grant_id_o(grant_id_o), .fence_done_i(fence_done_i), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: an outstanding-packet slot, a pending-fence flag and a
  // count of consecutive req0 losses.
  logic [W-1:0] m_queue[$];
  int           m_ids[$];
  bit           m_fence_wait;
  int           m_starve;

  // Last observed output, captured by tick for scenario-level checks.
  logic         obs_v;
  logic         obs_id;

  task automatic chk(string tag, logic [127:0] observed, logic [127:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [W-1:0] mk_pkt(logic [OPW-1:0] op);
    logic [95:0] r;
    r = {$urandom(), $urandom(), $urandom()};
    return {op, r[W-OPW-1:0]};
  endfunction

  task automatic model_reset();
    m_queue.delete();
    m_ids.delete();
    m_fence_wait = 1'b0;
    m_starve     = 0;
  endtask

  // One clock cycle: check outputs mid-cycle against the model, then advance
  // the model by the rules using the inputs held this cycle.
  task automatic tick();
    bit held, fence_held, can_take;
    int winner;
    @(negedge clk);
    held       = (m_queue.size() != 0);
    fence_held = held && (m_queue[0][W-1 -: OPW] == e_dcache_op_fencei);
    can_take   = !m_fence_wait && (!held || (dcache_ready_i && !fence_held));
    winner     = -1;
    if (can_take) begin
      if (req1_v_i && m_starve < LIMIT) winner = 1;
      else if (req0_v_i)                winner = 0;
      else if (req1_v_i)                winner = 1;
    end
    chk("req0_ready", req0_ready_o, can_take && winner == 0);
    chk("req1_ready", req1_ready_o, can_take && winner == 1);
    chk("dcache_v",   dcache_v_o,   held);
    chk("busy",       busy_o,       held || m_fence_wait);
    if (held) begin
      chk("dcache_pkt", dcache_pkt_o, m_queue[0]);
      chk("grant_id",   grant_id_o,   m_ids[0][0]);
    end
    obs_v  = dcache_v_o;
    obs_id = grant_id_o;

    if (m_fence_wait) begin
      if (fence_done_i) m_fence_wait = 1'b0;
    end else if (held && dcache_ready_i) begin
      void'(m_queue.pop_front());
      void'(m_ids.pop_front());
      if (fence_held) m_fence_wait = 1'b1;
    end
    if (winner >= 0) begin
      m_queue.push_back(winner == 1 ? req1_pkt_i : req0_pkt_i);
      m_ids.push_back(winner);
    end
    if (winner == 1 && req0_v_i) m_starve = (m_starve + 1 > LIMIT) ? LIMIT : m_starve + 1;
    else if (winner == 0)        m_starve = 0;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req0_v_i = 1'b0; req1_v_i = 1'b0;
    fence_done_i = 1'b0;
    dcache_ready_i = 1'b1;
  endtask

  task automatic check_reset_outputs(string tag);
    chk({tag, "_v"},      dcache_v_o,   1'b0);
    chk({tag, "_busy"},   busy_o,       1'b0);
    chk({tag, "_id"},     grant_id_o,   1'b0);
    chk({tag, "_pkt"},    dcache_pkt_o, '0);
    chk({tag, "_ready0"}, req0_ready_o, 1'b0);
    chk({tag, "_ready1"}, req1_ready_o, 1'b0);
  endtask

  int grants[10];
  int expected_order[10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
  int stream_cnt;

  initial begin
    // Reset state with requests pending: nothing may be accepted.
    reset_n_i = 1'b0;
    idle_inputs();
    req0_v_i = 1'b1; req1_v_i = 1'b1;
    req0_pkt_i = mk_pkt(e_dcache_op_lw);
    req1_pkt_i = mk_pkt(e_dcache_op_ld);
    model_reset();
    #2;
    check_reset_outputs("reset");
    @(posedge clk); #1;
    reset_n_i = 1'b1;
    idle_inputs();

    // Single req0 lw: ready in cycle 0, presented in cycle 1, idle in cycle 2.
    req0_v_i = 1'b1; req0_pkt_i = mk_pkt(e_dcache_op_lw);
    tick();
    idle_inputs();
    tick();
    chk("single_v",  obs_v,  1'b1);
    chk("single_id", obs_id, 1'b0);
    tick();
    chk("single_idle_busy", busy_o, 1'b0);

    // Back-pressure on a req1 packet for 3 cycles, req0 pressing too.
    req1_v_i = 1'b1; req1_pkt_i = mk_pkt(e_dcache_op_ld);
    tick();
    req1_v_i = 1'b0; dcache_ready_i = 1'b0;
    req0_v_i = 1'b1; req0_pkt_i = mk_pkt(e_dcache_op_sw);
    repeat (3) tick();
    req0_v_i = 1'b0; dcache_ready_i = 1'b1;
    tick();
    tick();
    chk("bp_retired", busy_o, 1'b0);

    // Starvation: both valid continuously.
    req0_v_i = 1'b1; req1_v_i = 1'b1;
    tick();
    for (int i = 0; i < 10; i++) begin
      req0_pkt_i = mk_pkt(e_dcache_op_lw);
      req1_pkt_i = mk_pkt(e_dcache_op_ld);
      tick();
      grants[i] = obs_v ? int'(obs_id) : -1;
    end
    for (int i = 0; i < 10; i++) chk($sformatf("starve_order%0d", i), grants[i], expected_order[i]);
    idle_inputs();
    tick();
    tick();

    // Fence: accept in cycle 0, fence_done in cycle 6, ready again in cycle 7.
    req0_v_i = 1'b1; req0_pkt_i = mk_pkt(e_dcache_op_fencei);
    tick();                                   // cycle 0
    req0_pkt_i = mk_pkt(e_dcache_op_lw);
    tick();                                   // cycle 1
    for (int c = 2; c <= 6; c++) begin
      fence_done_i = (c == 6);
      chk($sformatf("fence_busy_c%0d", c), busy_o, 1'b1);
      tick();
    end
    fence_done_i = 1'b0;
    chk("fence_c7_busy", busy_o, 1'b0);
    chk("fence_c7_ready0", req0_ready_o, 1'b1);
    tick();                                   // cycle 7: lw accepted
    req0_v_i = 1'b0;
    tick();
    tick();

    // Fence completion pulse outside FENCE must have no effect.
    fence_done_i = 1'b1;
    tick();
    fence_done_i = 1'b0;

    // Streaming: 8 back-to-back sd from req0.
    stream_cnt = 0;
    for (int i = 0; i < 9; i++) begin
      req0_v_i = (i < 8);
      req0_pkt_i = mk_pkt(e_dcache_op_sd);
      tick();
      if (i >= 1 && obs_v) stream_cnt++;
    end
    chk("stream_count", stream_cnt, 8);
    idle_inputs();
    tick();

    // Mid-operation reset while holding a packet under back-pressure.
    req0_v_i = 1'b1; req0_pkt_i = mk_pkt(e_dcache_op_sd);
    tick();
    dcache_ready_i = 1'b0;
    tick();
    #2 reset_n_i = 1'b0;
    #1;
    check_reset_outputs("midrst_hold");
    model_reset();
    req0_v_i = 1'b0; dcache_ready_i = 1'b1;
    @(posedge clk); #1;
    reset_n_i = 1'b1;
    repeat (3) tick();

    // Mid-operation reset while waiting for fence completion.
    req1_v_i = 1'b1; req1_pkt_i = mk_pkt(e_dcache_op_fencei);
    tick();
    req1_v_i = 1'b0;
    tick();
    tick();
    chk("midrst_fence_busy", busy_o, 1'b1);
    #2 reset_n_i = 1'b0;
    #1;
    check_reset_outputs("midrst_fence");
    model_reset();
    @(posedge clk); #1;
    reset_n_i = 1'b1;
    repeat (3) tick();

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      req0_v_i       = ($urandom_range(0, 3) != 0);
      req1_v_i       = ($urandom_range(0, 2) == 0);
      req0_pkt_i     = mk_pkt(($urandom_range(0, 9) == 0) ? e_dcache_op_fencei : e_dcache_op_lw);
      req1_pkt_i     = mk_pkt(($urandom_range(0, 15) == 0) ? e_dcache_op_fencei : e_dcache_op_ld);
      dcache_ready_i = ($urandom_range(0, 3) != 0);
      fence_done_i   = ($urandom_range(0, 3) == 0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
